hash_writer: RTL
================

# hash_writer

Transmit-side counterpart to the hash collector. It takes a finished 256-bit hash vector, splits it into HASH_LENGTH 32-bit words and writes them to the hash memory one word per accepted cycle, driving `hash_write`, `hash_address` and `hash_data`. It sits between the compression core's final hash register and the output memory, and reports completion to the top-level controller.

## Interface
Parameters:
- HASH_LENGTH, 8, number of 32-bit words per hash; vector width is 32*HASH_LENGTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  block enable; low forces synchronous return to IDLE.
- start  input  1  request to transmit `hash_vector`; sampled only in IDLE.
- hash_vector  input  32*HASH_LENGTH  hash to transmit; word i is bits [32i+31:32i].
- mem_ready  input  1  memory accepts the current word this cycle.
- hash_write  output  1  write strobe; word valid on `hash_address`/`hash_data`.
- hash_address  output  $clog2(HASH_LENGTH)  word address being written.
- hash_data  output  32  word being written.
- busy  output  1  high from start acceptance until DONE exits.
- hash_write_complete  output  1  one-cycle pulse after last word accepted.

## Operation
- States: IDLE, WRITE, DONE (2-bit encoded).
- IDLE: outputs idle. If `enable && start`, capture `hash_vector` into an internal shadow register, clear the word counter, set `busy`, go to WRITE. `hash_vector` is not sampled again until next start.
- WRITE: `hash_write`=1, `hash_address`=counter, `hash_data`=shadow word[counter]. A word is accepted on a cycle where `hash_write && mem_ready`. On acceptance: if counter == HASH_LENGTH-1, go to DONE; else counter+1. If `mem_ready`=0, hold address and data unchanged (no skip, no repeat).
- DONE: `hash_write`=0, `hash_write_complete`=1 for exactly this cycle, `busy` stays 1; next state IDLE.
- `start` outside IDLE is ignored (no queueing, no restart).
- `enable`=0 in any state: next edge goes to IDLE, `hash_write`=0, `busy`=0, counter cleared, no completion pulse. Partially written words are not retracted.
- Counter is $clog2(HASH_LENGTH) bits; never wraps because the transition to DONE occurs at HASH_LENGTH-1.
- All outputs registered.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE, counter 0, shadow 0, `hash_write`=0, `hash_address`=0, `hash_data`=0, `busy`=0, `hash_write_complete`=0. Reset mid-transfer aborts immediately, no pulse.
- Start accepted at edge E0: `busy` high and word 0 presented after E0 (cycle 1).
- With `mem_ready` held high: words 0..7 on cycles 1..8, `hash_write_complete` on cycle 9, `busy` low and IDLE from cycle 10; next start accepted at the edge ending cycle 10 at earliest. Total 9 cycles start-to-done.
- Each low cycle of `mem_ready` during WRITE adds exactly one cycle of latency.
- `hash_address`/`hash_data` hold their last values when `hash_write`=0 after DONE; they are don't-care while `hash_write`=0.
- `start` and `enable` falling simultaneously in IDLE: enable wins, no transfer.

## Test plan
- Reset then `hash_vector`=0x00000007_00000006_..._00000000, start pulse, `mem_ready`=1 -> addresses 0..7 on consecutive cycles with data 0..7, pulse on cycle 9, `busy` low cycle 10.
- Same vector, `mem_ready` low on cycles 3 and 4 -> address 2/data 2 held for 3 cycles, completion on cycle 11, no duplicate or skipped address.
- Change `hash_vector` to all-ones and pulse `start` while on word 3 -> data continues from captured vector, second start ignored, single completion pulse.
- Drop `enable` during word 5 -> `hash_write` 0 next cycle, `busy` 0, no completion pulse; subsequent start transmits all 8 words from address 0.
- Assert `reset` low asynchronously mid-WRITE (between edges) -> all outputs 0 immediately; after release, start with 0xDEADBEEF in word 7 -> address 7 carries 0xDEADBEEF.
- Back-to-back: start held high continuously -> second transfer begins the cycle after return to IDLE, two completion pulses 10 cycles apart.

Source files
------------

// File: rtl/hash_writer_if.sv
// Hash writer bus: start/vector request side plus the memory write port.
// The writer takes the master modport; the environment takes the slave modport.
interface hash_writer_if #(
  parameter int HASH_LENGTH = 8
);
  localparam int AW = (HASH_LENGTH > 1) ? $clog2(HASH_LENGTH) : 1;

  logic                      start;
  logic [32*HASH_LENGTH-1:0] hash_vector;
  logic                      mem_ready;
  logic                      hash_write;
  logic [AW-1:0]             hash_address;
  logic [31:0]               hash_data;
  logic                      busy;
  logic                      hash_write_complete;

  modport master (
    input  start, hash_vector, mem_ready,
    output hash_write, hash_address, hash_data, busy, hash_write_complete
  );

  modport slave (
    output start, hash_vector, mem_ready,
    input  hash_write, hash_address, hash_data, busy, hash_write_complete
  );
endinterface

// File: rtl/hash_writer.sv
// hash_writer: captures a finished hash into a shadow register and streams it
// to the hash memory one 32-bit word per accepted cycle, then pulses completion.
module hash_writer #(
  parameter int HASH_LENGTH = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  hash_writer_if.master bus
);
  localparam int AW = (HASH_LENGTH > 1) ? $clog2(HASH_LENGTH) : 1;
  localparam int VW = 32 * HASH_LENGTH;
  localparam logic [AW-1:0] LAST_IDX = AW'(HASH_LENGTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   counter_q, counter_d;
  logic [VW-1:0]   shadow_q, shadow_d;
  logic            write_q, write_d;
  logic [31:0]     data_q, data_d;
  logic            busy_q, busy_d;
  logic            complete_q, complete_d;

  // Select 32-bit word idx out of a hash vector.
  function automatic logic [31:0] word_of(input logic [VW-1:0] vec,
                                          input logic [AW-1:0] idx);
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < HASH_LENGTH; i++) begin
      if (idx == AW'(i)) begin
        w = vec[32*i +: 32];
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  // Next-state and next-output logic; outputs are precomputed so they leave flops.
  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    shadow_d   = shadow_q;
    write_d    = write_q;
    data_d     = data_q;
    busy_d     = busy_q;
    complete_d = 1'b0;
    if (!enable) begin
      // Abort: already written words stay written, no completion reported.
      state_d   = ST_IDLE;
      counter_d = '0;
      write_d   = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          write_d = 1'b0;
          busy_d  = 1'b0;
          if (bus.start) begin
            shadow_d  = bus.hash_vector;
            counter_d = '0;
            data_d    = bus.hash_vector[31:0];
            write_d   = 1'b1;
            busy_d    = 1'b1;
            state_d   = ST_WRITE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (write_q && bus.mem_ready) begin
            if (counter_q == LAST_IDX) begin
              // Counter stays on the last index, so the address holds afterwards.
              write_d    = 1'b0;
              complete_d = 1'b1;
              state_d    = ST_DONE;
            end else begin
              counter_d = counter_q + AW'(1);
              data_d    = word_of(shadow_q, counter_q + AW'(1));
            end
          end else begin
            // Memory stalled: present the same word again.
            state_d = ST_WRITE;
          end
        end
        ST_DONE: begin
          write_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: begin
          state_d   = ST_IDLE;
          counter_d = '0;
          write_d   = 1'b0;
          busy_d    = 1'b0;
        end
      endcase
    end
  end

  // State, shadow and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      counter_q  <= '0;
      shadow_q   <= '0;
      write_q    <= 1'b0;
      data_q     <= 32'd0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      shadow_q   <= shadow_d;
      write_q    <= write_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      complete_q <= complete_d;
    end
  end

  assign bus.hash_write          = write_q;
  assign bus.hash_address        = counter_q;
  assign bus.hash_data           = data_q;
  assign bus.busy                = busy_q;
  assign bus.hash_write_complete = complete_q;
endmodule
